// File: rtl/conv_sched_ctrl_pkg.sv
// Shared types and sizing for the convolution pass scheduler.
package conv_sched_ctrl_pkg;

  localparam int unsigned TENSOR_SIZE = 8;
  localparam int unsigned SCHED_CNT_W = TENSOR_SIZE * 2 + 1;
  localparam int unsigned SCHED_TO_W  = 12;
  localparam int unsigned SCHED_ST_W  = 3;

  typedef enum logic [SCHED_ST_W-1:0] {
    SCHED_IDLE,
    SCHED_PREP,
    SCHED_LOAD_W,
    SCHED_FETCH,
    SCHED_MAC,
    SCHED_WB,
    SCHED_FIN,
    SCHED_ERR
  } sched_state_t;

  // States that run a start-pulse / done-pulse handshake with a downstream block.
  function automatic logic is_stage(input sched_state_t s);
    return (s == SCHED_LOAD_W) || (s == SCHED_FETCH) ||
           (s == SCHED_MAC)    || (s == SCHED_WB);
  endfunction

endpackage

// File: rtl/conv_sched_ctrl_watchdog.sv
// Stage timeout counter: cleared by clr, counts while en, flags the final wait cycle.
module sched_watchdog #(
  parameter int unsigned TO_W = 12
) (
  input  logic clk,
  input  logic rstn,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TO_W-1:0] LIMIT = '1;

  logic [TO_W-1:0] cnt;

  // Saturating wait-cycle counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != LIMIT)) begin
      cnt <= cnt + TO_W'(1);
    end
  end

  // Asserted in the wait cycle whose increment makes the count reach its limit.
  assign expire = en && !clr && (cnt == (LIMIT - TO_W'(1)));

endmodule

// File: rtl/conv_sched_ctrl.sv
// Sequencer for one IMG2COL convolution pass: prepare, weight load, then per-tile
// fetch -> MAC -> write-back, with a per-stage watchdog and abort.
module conv_sched_ctrl
  import conv_sched_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = SCHED_CNT_W,
  parameter int unsigned TO_W  = SCHED_TO_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  output logic             pp_start,
  input  logic             pp_enable,
  input  logic [CNT_W-1:0] tile_num,
  output logic             w_start,
  input  logic             w_done,
  output logic             t_start,
  input  logic             t_done,
  output logic             mac_start,
  input  logic             mac_done,
  output logic             wb_start,
  input  logic             wb_done,
  output logic [CNT_W-1:0] tile_idx,
  output logic             last_tile,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  sched_state_t     state;
  logic             issued;   // 0: issue cycle of a stage, 1: waiting for its done
  logic [CNT_W-1:0] tn_lat;
  logic             wd_clr;
  logic             wd_en;
  logic             wd_expire;

  // Watchdog counts in PREP and in stage wait phases; every other cycle clears it,
  // which covers "cleared on state entry" because each counting phase is preceded
  // by IDLE or a stage issue cycle.
  always_comb begin
    wd_en  = 1'b0;
    wd_clr = 1'b1;
    if ((state == SCHED_PREP) || (is_stage(state) && issued)) begin
      wd_en  = 1'b1;
      wd_clr = 1'b0;
    end
  end

  sched_watchdog #(.TO_W(TO_W)) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  // Pass sequencer with registered outputs; abort overrides every transition.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= SCHED_IDLE;
      issued    <= 1'b0;
      tn_lat    <= '0;
      pp_start  <= 1'b0;
      w_start   <= 1'b0;
      t_start   <= 1'b0;
      mac_start <= 1'b0;
      wb_start  <= 1'b0;
      tile_idx  <= '0;
      last_tile <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else if (abort && (state != SCHED_IDLE)) begin
      state     <= SCHED_IDLE;
      issued    <= 1'b0;
      pp_start  <= 1'b0;
      w_start   <= 1'b0;
      t_start   <= 1'b0;
      mac_start <= 1'b0;
      wb_start  <= 1'b0;
      tile_idx  <= '0;
      last_tile <= (tn_lat == ONE);
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        SCHED_IDLE: begin
          if (start) begin
            state     <= SCHED_PREP;
            pp_start  <= 1'b1;
            busy      <= 1'b1;
            tile_idx  <= '0;
            last_tile <= (tn_lat == ONE);
          end
        end
        SCHED_PREP: begin
          if (pp_enable) begin
            tn_lat    <= tile_num;
            pp_start  <= 1'b0;
            last_tile <= (tile_num == ONE);
            if (tile_num == '0) begin
              state <= SCHED_FIN;
              done  <= 1'b1;
            end else begin
              state   <= SCHED_LOAD_W;
              issued  <= 1'b0;
              w_start <= 1'b1;
            end
          end else if (wd_expire) begin
            state    <= SCHED_ERR;
            pp_start <= 1'b0;
            err      <= 1'b1;
          end
        end
        SCHED_LOAD_W: begin
          if (!issued) begin
            issued  <= 1'b1;
            w_start <= 1'b0;
          end else if (w_done) begin
            state   <= SCHED_FETCH;
            issued  <= 1'b0;
            t_start <= 1'b1;
          end else if (wd_expire) begin
            state <= SCHED_ERR;
            err   <= 1'b1;
          end
        end
        SCHED_FETCH: begin
          if (!issued) begin
            issued  <= 1'b1;
            t_start <= 1'b0;
          end else if (t_done) begin
            state     <= SCHED_MAC;
            issued    <= 1'b0;
            mac_start <= 1'b1;
          end else if (wd_expire) begin
            state <= SCHED_ERR;
            err   <= 1'b1;
          end
        end
        SCHED_MAC: begin
          if (!issued) begin
            issued    <= 1'b1;
            mac_start <= 1'b0;
          end else if (mac_done) begin
            state    <= SCHED_WB;
            issued   <= 1'b0;
            wb_start <= 1'b1;
          end else if (wd_expire) begin
            state <= SCHED_ERR;
            err   <= 1'b1;
          end
        end
        SCHED_WB: begin
          if (!issued) begin
            issued   <= 1'b1;
            wb_start <= 1'b0;
          end else if (wb_done) begin
            issued <= 1'b0;
            if (last_tile) begin
              state <= SCHED_FIN;
              done  <= 1'b1;
            end else begin
              state     <= SCHED_FETCH;
              t_start   <= 1'b1;
              tile_idx  <= tile_idx + ONE;
              last_tile <= ((tile_idx + ONE) == (tn_lat - ONE));
            end
          end else if (wd_expire) begin
            state <= SCHED_ERR;
            err   <= 1'b1;
          end
        end
        SCHED_FIN: begin
          state <= SCHED_IDLE;
          busy  <= 1'b0;
        end
        SCHED_ERR: begin
          state <= SCHED_ERR;
        end
        default: begin
          state <= SCHED_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Self-checking bench: stage responders with random latency, an event log of the DUT
// outputs, and an expected event sequence built from tile count and latency.
module tb_conv_sched_ctrl;

  localparam int unsigned CNT_W = 17;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             pp_start;
  logic             pp_enable = 1'b0;
  logic [CNT_W-1:0] tile_num = '0;
  logic             w_start, t_start, mac_start, wb_start;
  logic             w_done = 1'b0, t_done = 1'b0, mac_done = 1'b0, wb_done = 1'b0;
  logic [CNT_W-1:0] tile_idx;
  logic             last_tile, busy, done, err;

  conv_sched_ctrl #(.CNT_W(CNT_W), .TO_W(4)) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .pp_start(pp_start), .pp_enable(pp_enable), .tile_num(tile_num),
    .w_start(w_start), .w_done(w_done), .t_start(t_start), .t_done(t_done),
    .mac_start(mac_start), .mac_done(mac_done), .wb_start(wb_start), .wb_done(wb_done),
    .tile_idx(tile_idx), .last_tile(last_tile), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  // ---------------- stage responders ----------------
  int fixed_lat = 0;
  bit drop_t = 1'b0;
  bit early_mac = 1'b0;
  int pp_cnt = 0, w_cnt = 0, t_cnt = 0, m_cnt = 0, b_cnt = 0;

  function automatic int pick_lat();
    return (fixed_lat > 0) ? fixed_lat : int'($urandom_range(8, 1));
  endfunction

  task automatic clear_resp();
    pp_cnt = 0; w_cnt = 0; t_cnt = 0; m_cnt = 0; b_cnt = 0;
    pp_enable = 1'b0; w_done = 1'b0; t_done = 1'b0; mac_done = 1'b0; wb_done = 1'b0;
  endtask

  initial forever begin
    @(negedge clk);
    pp_enable = 1'b0; w_done = 1'b0; t_done = 1'b0; mac_done = 1'b0; wb_done = 1'b0;
    if (pp_cnt > 0) begin pp_cnt--; if (pp_cnt == 0) pp_enable = 1'b1; end
    if (w_cnt > 0)  begin w_cnt--;  if (w_cnt == 0)  w_done = 1'b1; end
    if (t_cnt > 0)  begin t_cnt--;  if (t_cnt == 0)  t_done = 1'b1; end
    if (m_cnt > 0)  begin m_cnt--;  if (m_cnt == 0)  mac_done = 1'b1; end
    if (b_cnt > 0)  begin b_cnt--;  if (b_cnt == 0)  wb_done = 1'b1; end
    if (pp_start && pp_cnt == 0 && !pp_enable) pp_cnt = pick_lat();
    if (w_start) w_cnt = pick_lat();
    if (t_start && !drop_t) t_cnt = pick_lat();
    if (mac_start) begin
      m_cnt = pick_lat();
      if (early_mac) mac_done = 1'b1;
    end
    if (wb_start) b_cnt = pick_lat();
  end

  // ---------------- output event log ----------------
  byte ev_q[$];
  int  ts_q[$];
  int  tq[$];
  bit  lq[$];
  bit  bq[$];
  int  cyc = 0;
  bit  pp_prev = 1'b0;

  task automatic log_ev(input byte c);
    ev_q.push_back(c);
    ts_q.push_back(cyc);
  endtask

  initial forever begin
    @(negedge clk);
    cyc++;
    if (pp_start && !pp_prev) log_ev("P");
    pp_prev = pp_start;
    if (w_start) log_ev("W");
    if (t_start) begin log_ev("T"); tq.push_back(int'(tile_idx)); end
    if (mac_start) log_ev("M");
    if (wb_start) begin log_ev("B"); lq.push_back(last_tile); end
    if (done) begin log_ev("D"); bq.push_back(busy); end
  end

  task automatic clear_log();
    ev_q.delete(); ts_q.delete(); tq.delete(); lq.delete(); bq.delete();
  endtask

  // One full pass of n tiles; lat > 0 fixes every responder latency and enables gap checks.
  task automatic run_pass(input int n, input int lat, input string tag);
    byte exp_q[$];
    bit  seen_pp, seen_done, finished;
    int  k;
    fixed_lat = lat;
    @(negedge clk); #1;
    clear_log();
    tile_num = CNT_W'(n);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen_pp = 1'b0; seen_done = 1'b0; finished = 1'b0;
    for (int c = 0; c < 500 && !finished; c++) begin
      if (pp_start) seen_pp = 1'b1;
      if (seen_pp && !pp_start) tile_num = CNT_W'($urandom);
      if (done) seen_done = 1'b1;
      if (seen_done && !busy) finished = 1'b1;
      else @(negedge clk);
    end
    chk({tag, "_finish"}, finished, 1);
    @(negedge clk); #1;
    exp_q.push_back("P");
    if (n > 0) begin
      exp_q.push_back("W");
      for (int i = 0; i < n; i++) begin
        exp_q.push_back("T"); exp_q.push_back("M"); exp_q.push_back("B");
      end
    end
    exp_q.push_back("D");
    chk({tag, "_nev"}, ev_q.size(), exp_q.size());
    k = (ev_q.size() < exp_q.size()) ? ev_q.size() : exp_q.size();
    for (int i = 0; i < k; i++) chk({tag, "_ev"}, ev_q[i], exp_q[i]);
    if (lat > 0)
      for (int i = 1; i < k; i++) chk({tag, "_gap"}, ts_q[i] - ts_q[i-1], lat + 1);
    chk({tag, "_ntile"}, tq.size(), n);
    for (int i = 0; i < tq.size(); i++) chk({tag, "_tidx"}, tq[i], i);
    for (int i = 0; i < lq.size(); i++) chk({tag, "_last"}, lq[i], (i == n - 1) ? 1 : 0);
    for (int i = 0; i < bq.size(); i++) chk({tag, "_busy_at_done"}, bq[i], 1);
    chk({tag, "_busy_end"}, busy, 0);
    chk({tag, "_err_end"}, err, 0);
    if (n > 0) chk({tag, "_tidx_hold"}, tile_idx, n - 1);
  endtask

  // Poll for a condition on the DUT outputs at negedges, bounded.
  task automatic wait_mac_tile(input int t, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      if (mac_start && tile_idx == CNT_W'(t)) ok = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got 0 exp 1");
    $fatal(1);
  end

  initial begin
    bit ok;
    int mark, bad;
    repeat (3) @(negedge clk);
    chk("rst_outs", {pp_start, w_start, t_start, mac_start, wb_start, last_tile, busy, done, err}, 0);
    chk("rst_tidx", tile_idx, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // nominal
    run_pass(3, 4, "nominal");
    // randomized passes
    for (int r = 0; r < 6; r++) run_pass(int'($urandom_range(5, 1)), 0, "rand");
    // zero tiles
    run_pass(0, 3, "zero");
    // early mac_done coincident with mac_start
    early_mac = 1'b1;
    run_pass(2, 4, "early");
    early_mac = 1'b0;

    // abort in MAC of tile 1, coincident with mac_done
    fixed_lat = 4;
    @(negedge clk);
    tile_num = CNT_W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_mac_tile(1, ok);
    chk("abort_reach_mac1", ok, 1);
    repeat (4) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    #1;
    clear_resp();
    mark = ev_q.size();
    chk("abort_busy", busy, 0);
    chk("abort_tidx", tile_idx, 0);
    chk("abort_starts", {pp_start, w_start, t_start, mac_start, wb_start}, 0);
    chk("abort_done", done, 0);
    repeat (6) @(negedge clk);
    #1;
    bad = 0;
    for (int i = mark; i < ev_q.size(); i++) if (ev_q[i] == "B" || ev_q[i] == "D") bad++;
    chk("abort_no_wb_done", bad, 0);

    // watchdog on missing t_done
    drop_t = 1'b1;
    fixed_lat = 2;
    @(negedge clk);
    tile_num = CNT_W'(2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(negedge clk);
      if (t_start) ok = 1'b1;
    end
    chk("wd_reach_fetch", ok, 1);
    repeat (15) @(negedge clk);
    chk("wd_err_pre", err, 0);
    @(negedge clk);
    chk("wd_err", err, 1);
    chk("wd_starts", {pp_start, w_start, t_start, mac_start, wb_start}, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("wd_start_ignored_err", err, 1);
    chk("wd_start_ignored_busy", busy, 1);
    chk("wd_start_ignored_pp", pp_start, 0);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("wd_abort_err", err, 0);
    chk("wd_abort_busy", busy, 0);
    drop_t = 1'b0;
    #1;
    clear_resp();

    // async reset mid-WB, then a clean single-tile pass
    fixed_lat = 2;
    @(negedge clk);
    tile_num = CNT_W'(3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      if (wb_start) ok = 1'b1;
    end
    chk("rst_reach_wb", ok, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("midrst_outs", {pp_start, w_start, t_start, mac_start, wb_start, last_tile, busy, done, err}, 0);
    chk("midrst_tidx", tile_idx, 0);
    repeat (2) @(negedge clk);
    #1;
    clear_resp();
    rstn = 1'b1;
    run_pass(1, 3, "after_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
